// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: state encoding and default sizing.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_RAMP_STEP = 1;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running tick counter for one PWM period; held at zero while disabled.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  assign wrap = enable && tick && (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator with a one-deep duty handshake, boundary-aligned target
// updates and a rate-limited ramp of the applied duty.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             run,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_end,
  output logic [WIDTH-1:0] duty_cur,
  output logic             busy
);

  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);

  pwm_state_t       state;
  pwm_state_t       state_nxt;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             pend_vld;
  logic [WIDTH-1:0] pend_val;
  logic [WIDTH-1:0] target;
  logic             xfer;

  // Saturating move of cur toward tgt by at most STEP; never overshoots.
  function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      ramp_toward = ({1'b0, diff} > STEP) ? cur + STEP[WIDTH-1:0] : tgt;
    end else begin
      diff = cur - tgt;
      ramp_toward = ({1'b0, diff} > STEP) ? cur - STEP[WIDTH-1:0] : tgt;
    end
  endfunction

  pwm_period_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .enable (state != ST_STOP),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  assign period_end = wrap;
  assign duty_ready = !pend_vld;
  assign busy       = (duty_cur != target);
  assign xfer       = duty_valid && duty_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_STOP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:  if (run) state_nxt = ST_RUN;
      ST_RUN:   if (!run) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (run)       state_nxt = ST_RUN;
        else if (wrap) state_nxt = ST_STOP;
      end
      default:  state_nxt = ST_STOP;
    endcase
  end

  // While stopped a pending duty applies immediately; while running it waits
  // for the boundary, and the ramp at that boundary uses the old target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_val <= '0;
      target   <= '0;
      duty_cur <= '0;
    end else if (state == ST_STOP) begin
      if (pend_vld) begin
        target   <= pend_val;
        duty_cur <= pend_val;
        pend_vld <= 1'b0;
      end else if (xfer) begin
        pend_val <= duty_in;
        pend_vld <= 1'b1;
      end
    end else if (wrap) begin
      duty_cur <= ramp_toward(duty_cur, target);
      pend_vld <= 1'b0;
      if (xfer)          target <= duty_in;
      else if (pend_vld) target <= pend_val;
    end else if (xfer) begin
      pend_val <= duty_in;
      pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= 1'b0;
    else        pwm_out <= (state != ST_STOP) && (cnt < duty_cur);
  end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, PWM counter and duty width; the period is 2^WIDTH ticks.
REQ-002 SHALL provide parameter RAMP_STEP, default 1, the maximum change of the applied duty per period boundary.
REQ-003 SHALL provide CLK  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL provide RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide TICK  input  1  single-cycle step enable from the enable generator (kHz-rate enable).
REQ-006 SHALL provide RUN  input  1  level; 1 = generate PWM, 0 = stop after the current period.
REQ-007 SHALL provide DUTY_IN  input  WIDTH  requested duty (target) from the serial command stage.
REQ-008 SHALL provide DUTY_VALID  input  1  DUTY_IN valid; transfer occurs when DUTY_VALID and DUTY_READY are both 1.
REQ-009 SHALL provide DUTY_READY  output  1  1 = no target pending; may accept a new target.
REQ-010 SHALL provide PWM_OUT  output  1  registered PWM waveform.
REQ-011 SHALL provide PERIOD_END  output  1  one-cycle pulse on the TICK that wraps the counter.
REQ-012 SHALL provide DUTY_CUR  output  WIDTH  currently applied duty.
REQ-013 SHALL provide BUSY  output  1  1 while DUTY_CUR differs from the latched target.

Function
REQ-014 SHALL keep states STOP, RUN and DRAIN.
- STOP -> RUN when RUN=1.
- RUN -> DRAIN when RUN=0.
- DRAIN -> RUN when RUN=1.
- DRAIN -> STOP on PERIOD_END.
REQ-015 SHALL, in RUN and DRAIN, advance cnt by 1 on each cycle where TICK=1, wrapping 2^WIDTH-1 -> 0; TICK=0 holds cnt.
REQ-016 SHALL pulse PERIOD_END for exactly one cycle when cnt wraps; PERIOD_END SHALL never assert in STOP.
REQ-017 SHALL register PWM_OUT <= (state != STOP) && (cnt < DUTY_CUR) every cycle, giving one clock of latency from cnt.
REQ-018 SHALL give duty 0 -> PWM_OUT constantly 0; duty 2^WIDTH-1 -> high for 2^WIDTH-1 of 2^WIDTH ticks; 100% is not representable.
REQ-019 SHALL, in STOP, hold cnt=0 and PWM_OUT=0.
REQ-020 SHALL, on a transfer, store DUTY_IN as the pending value and drive DUTY_READY=0 until that value is latched as the target.
REQ-021 SHALL latch the pending value as the target at the next period boundary while in RUN/DRAIN; in STOP it SHALL latch on the cycle after the transfer, setting both target and DUTY_CUR with no ramp.
REQ-022 SHALL, when a transfer coincides with PERIOD_END, latch DUTY_IN directly as the target at that boundary; DUTY_READY stays 1.
REQ-023 SHALL, at each period boundary, move DUTY_CUR toward the target by min(RAMP_STEP, |target-DUTY_CUR|), with no overshoot or wrap.
REQ-024 SHALL use the target that existed before the boundary for the ramp step when a new target latches at that same boundary.
REQ-025 SHALL ignore DUTY_VALID while DUTY_READY=0; DUTY_IN SHALL NOT be sampled then.

Reset
REQ-026 SHALL, while RST_N=0, force: state=STOP, cnt=0, pending flag=0, target=0, DUTY_CUR=0, PWM_OUT=0, PERIOD_END=0, BUSY=0, DUTY_READY=1.
REQ-027 SHALL return to the reset values immediately when RST_N asserts mid-period or mid-ramp, and SHALL leave STOP only on RUN=1 after RST_N deasserts.

Structure
REQ-028 SHALL place the state encodings (STOP/RUN/DRAIN) and default WIDTH/RAMP_STEP in shared package pwm_pkg.
REQ-029 SHALL split the tick counter and wrap detection into sub-module pwm_period_counter (inputs CLK, RST_N, TICK, enable; outputs cnt, wrap); all else stays in pwm_gen.

Verification
REQ-030 SHALL cover: WIDTH=8, TICK every cycle, STOP, transfer 64 -> DUTY_CUR=64 next cycle; RUN=1 -> PWM_OUT high 64 of each 256 cycles; PERIOD_END every 256 cycles.
REQ-031 SHALL cover: RUN, DUTY_CUR=10, RAMP_STEP=4, transfer 20 -> DUTY_CUR goes 14, 18, 20 at successive boundaries; BUSY is 1 until 20 is reached, then 0.
REQ-032 SHALL cover: transfer 100 mid-period -> DUTY_READY=0 until the next PERIOD_END; a second DUTY_VALID during that window is ignored; target=100.
REQ-033 SHALL cover: transfer coincident with PERIOD_END -> target latched that cycle and DUTY_READY never drops.
REQ-034 SHALL cover: RUN=0 at cnt=50 -> DRAIN, PWM continues to the wrap, then STOP with PWM_OUT=0; RUN=1 in DRAIN at cnt=200 -> RUN with no gap.
REQ-035 SHALL cover: RST_N=0 at cnt=128 during a ramp -> all outputs are at reset values at once and DUTY_READY=1; duty 0 and 255 edge waveforms are checked.
